// File: rtl/case6_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : case6_sweep_pkg
//  Purpose  : Shared types, constants and the MISR step function used by the
//             exhaustive-pattern sweep controller and its signature register.
//  Contents : sweep_state_t, SIG_POLY, SIG_SEED, misr_next()
//  Revision : 1.0  initial release
// ============================================================================
package case6_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE_W = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } sweep_state_t;

  // CCITT-style feedback polynomial and all-ones seed for the 16-bit MISR.
  localparam logic [15:0] SIG_POLY = 16'h1021;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // One MISR step: shift left, fold the MSB back through the polynomial and
  // XOR in the (zero-extended) block outputs.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [15:0] res);
    return {sig[14:0], 1'b0} ^ (sig[15] ? SIG_POLY : 16'h0000) ^ res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/case6_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : case6_sweep_ctrl_if
//  Purpose  : Bundle between the harness and the sweep controller.
//  Signals  : start, abort      harness -> controller control
//             res_i             block outputs -> controller
//             pat_o             controller -> block inputs
//             busy, done        controller status
//             sig_o, vec_cnt    signature and captured-vector count
//             golden_i, pass, fail  only with CASE6_SWEEP_GOLDEN_CMP_EN
//  Modports : master (harness side), slave (controller side)
//  Revision : 1.0  initial release
// ============================================================================
interface case6_sweep_ctrl_if #(
  parameter int N_IN  = 6,
  parameter int N_OUT = 3,
  parameter int SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  pat_o;
  logic [N_OUT-1:0] res_i;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] sig_o;
  logic [N_IN:0]    vec_cnt;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
  logic [SIG_W-1:0] golden_i;
  logic             pass;
  logic             fail;

  modport master (output start, abort, res_i, golden_i,
                  input  pat_o, busy, done, sig_o, vec_cnt, pass, fail);
  modport slave  (input  start, abort, res_i, golden_i,
                  output pat_o, busy, done, sig_o, vec_cnt, pass, fail);
`else
  modport master (output start, abort, res_i,
                  input  pat_o, busy, done, sig_o, vec_cnt);
  modport slave  (input  start, abort, res_i,
                  output pat_o, busy, done, sig_o, vec_cnt);
`endif
endinterface
`default_nettype wire

// File: rtl/case6_sweep_misr.sv
`default_nettype none
// ============================================================================
//  Module   : case6_sweep_misr
//  Purpose  : Multiple-input signature register with synchronous load/enable.
//  Ports    : clk, rst_n (async, active low)
//             load_i  reseed to all ones (wins over en_i)
//             en_i    fold res_i into the signature this cycle
//             res_i   block outputs, zero-extended into the signature
//             sig_o   current signature
//  Revision : 1.0  initial release
// ============================================================================
module case6_sweep_misr
  import case6_sweep_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int N_OUT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [N_OUT-1:0] res_i,
  output logic [SIG_W-1:0] sig_o
);

  localparam logic [SIG_W-1:0] c_seed = '1;

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] w_step;

  generate
    if (SIG_W == 16) begin : g_w16
      assign w_step = misr_next(sig_q, 16'(res_i));
    end else begin : g_generic
      localparam logic [SIG_W-1:0] c_poly = SIG_W'(SIG_POLY);
      assign w_step = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? c_poly : '0)
                    ^ SIG_W'(res_i);
    end
  endgenerate

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = c_seed;
    end else if (en_i) begin
      sig_d = w_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= c_seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule
`default_nettype wire

// File: rtl/case6_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : case6_sweep_ctrl
//  Purpose  : Exhaustive-pattern sequencer. Walks pat_o through every input
//             vector in ascending order, holds each for SETTLE+1 cycles,
//             folds res_i into a MISR on the last cycle of each hold and
//             pulses done after the all-ones vector is captured.
//  Ports    : clk, rst_n (async, active low)
//             bus (slave modport): start, abort, res_i -> in;
//                                  pat_o, busy, done, sig_o, vec_cnt -> out
//  Option   : CASE6_SWEEP_GOLDEN_CMP_EN adds golden_i, pass, fail
//  Revision : 1.0  initial release
// ============================================================================
module case6_sweep_ctrl
  import case6_sweep_pkg::*;
#(
  parameter int N_IN   = 6,
  parameter int N_OUT  = 3,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  case6_sweep_ctrl_if.slave  bus
);

  localparam int                c_cnt_w    = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_settle  = c_cnt_w'(SETTLE);
  localparam logic [N_IN-1:0]   c_pat_last = '1;
  // With no settle time every vector goes straight to capture.
  localparam sweep_state_t      c_first    = (SETTLE == 0) ? CAPTURE : SETTLE_W;

  sweep_state_t       state_q, state_d;
  logic [N_IN-1:0]    pat_q,   pat_d;
  logic [c_cnt_w-1:0] cnt_q,   cnt_d;
  logic [N_IN:0]      vec_q,   vec_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               w_misr_load;
  logic               w_misr_en;
  logic [SIG_W-1:0]   w_sig;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
  logic               pass_q,  pass_d;
  logic               fail_q,  fail_d;
`endif

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    w_misr_load = 1'b0;
    w_misr_en   = 1'b0;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
    pass_d      = pass_q;
    fail_d      = fail_q;
`endif

    if (bus.abort) begin
      // Abort outranks everything, including a start in IDLE; signature,
      // count and pattern keep their partial values.
      state_d = IDLE;
      busy_d  = 1'b0;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
      pass_d  = 1'b0;
      fail_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d     = c_first;
            pat_d       = '0;
            cnt_d       = c_settle;
            vec_d       = '0;
            busy_d      = 1'b1;
            w_misr_load = 1'b1;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
            pass_d      = 1'b0;
            fail_d      = 1'b0;
`endif
          end
        end
        SETTLE_W: begin
          cnt_d = cnt_q - c_cnt_w'(1);
          if (cnt_q <= c_cnt_w'(1)) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          w_misr_en = 1'b1;
          vec_d     = vec_q + (N_IN + 1)'(1);
          if (pat_q == c_pat_last) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pat_d   = pat_q + N_IN'(1);
            cnt_d   = c_settle;
            state_d = c_first;
          end
        end
        DONE: begin
          state_d = IDLE;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
          // Signature is final in this cycle; the verdict appears next cycle.
          pass_d  = (w_sig == bus.golden_i);
          fail_d  = (w_sig != bus.golden_i);
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`endif
    end
  end

  case6_sweep_misr #(
    .SIG_W (SIG_W),
    .N_OUT (N_OUT)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_misr_load),
    .en_i   (w_misr_en),
    .res_i  (bus.res_i),
    .sig_o  (w_sig)
  );

  assign bus.pat_o   = pat_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.vec_cnt = vec_q;
  assign bus.sig_o   = w_sig;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_case6_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_case6_sweep_ctrl
//  Purpose  : Scoreboard bench for case6_sweep_ctrl. Three controllers with
//             SETTLE = 1, 0 and 3 share one stimulus stream; each has its own
//             monitor that consumes the expected-result queue.
//  Option   : CASE6_SWEEP_GOLDEN_CMP_EN also exercises golden_i/pass/fail
//  Revision : 1.0  initial release
// ============================================================================
module tb_case6_sweep_ctrl;

  localparam int K_NORM  = 0;
  localparam int K_ABORT = 1;
  localparam int K_RST   = 2;

  typedef struct {
    int           kind;
    int           abort_at;
    logic [191:0] tt;
    bit           gold_pass;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start_v;
  logic         abort_v;
  logic [191:0] tt_cur;
  bit           fin;
  int           checks;
  int           errors;
  exp_t         exp_q[$];

  logic [15:0]  sig_all[3];
  logic [6:0]   vec_all[3];
  logic [5:0]   pat_all[3];
  logic [2:0]   busy_all;
  logic [2:0]   done_all;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
  logic [15:0]  golden_v;
  logic [2:0]   pass_all;
  logic [2:0]   fail_all;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Signature after the first n vectors of truth table tt, straight from the
  // shift/poly/XOR rule using integer arithmetic.
  function automatic logic [15:0] model_sig(input logic [191:0] tt, input int n);
    int s;
    s = 'hFFFF;
    for (int i = 0; i < n; i++) begin
      s = ((s * 2) & 'hFFFF) ^ ((((s >> 15) & 1) != 0) ? 'h1021 : 0) ^ int'(tt[i*3 +: 3]);
    end
    return s[15:0];
  endfunction

  // Truth table of the block under test: 0 = all zero, 1 = fixed logic,
  // 2 = random.  Pattern bits are {a,b,c,d,e,f}, result {y1,y2,y3}.
  function automatic logic [191:0] mk_tt(input int mode);
    logic [191:0] t;
    logic [5:0]   p;
    logic [2:0]   y;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      p = 6'(i);
      if (mode == 1)
        y = {(p[5] & p[4]) | p[3], p[2] ^ p[1] ^ p[0],
             (p[5] & p[3]) | (p[5] & p[1]) | (p[3] & p[1])};
      else if (mode == 2)
        y = 3'($urandom_range(0, 7));
      else
        y = 3'b000;
      t[i*3 +: 3] = y;
    end
    return t;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int ST = (k == 0) ? 1 : ((k == 1) ? 0 : 3);

    case6_sweep_ctrl_if #(.N_IN(6), .N_OUT(3), .SIG_W(16)) bus ();

    case6_sweep_ctrl #(
      .N_IN   (6),
      .N_OUT  (3),
      .SETTLE (ST),
      .SIG_W  (16)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.start   = start_v;
    assign bus.abort   = abort_v;
    assign bus.res_i   = tt_cur[int'(bus.pat_o)*3 +: 3];
    assign sig_all[k]  = bus.sig_o;
    assign vec_all[k]  = bus.vec_cnt;
    assign pat_all[k]  = bus.pat_o;
    assign busy_all[k] = bus.busy;
    assign done_all[k] = bus.done;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
    assign bus.golden_i = golden_v;
    assign pass_all[k]  = bus.pass;
    assign fail_all[k]  = bus.fail;
`endif

    int          rd = 0;
    int          run = 0;
    int          cyc = 0;
    int          cur = 0;
    int          n = 0;
    bit          bad = 1'b0;
    bit          bprev = 1'b0;
    bit          dprev = 1'b0;
    bit          gpend = 1'b0;
    bit          gexp = 1'b0;
    bit          drained = 1'b0;
    exp_t        d;
    logic [15:0] esig;

    always @(negedge clk) begin
      if (dprev) check_eq($sformatf("done_one_cycle[st%0d]", ST), bus.done, 0);
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
      if (gpend) begin
        check_eq($sformatf("pass[st%0d]", ST), bus.pass, gexp);
        check_eq($sformatf("fail[st%0d]", ST), bus.fail, !gexp);
        gpend = 1'b0;
      end
`endif
      if (bus.busy) begin
        if (!bprev) begin
          run = 1; cyc = 1; cur = int'(bus.pat_o);
          bad = (bus.pat_o != 6'd0);
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
          check_eq($sformatf("pf_clear_on_start[st%0d]", ST), {bus.pass, bus.fail}, 0);
`endif
        end else begin
          cyc++;
          if (int'(bus.pat_o) == cur) run++;
          else begin
            if (run != ST + 1 || int'(bus.pat_o) != cur + 1) bad = 1'b1;
            cur = int'(bus.pat_o);
            run = 1;
          end
        end
      end
      if (bprev && !bus.busy) begin
        if (rd >= exp_q.size()) begin
          check_eq($sformatf("unexpected_end[st%0d]", ST), rd, exp_q.size());
        end else begin
          d = exp_q[rd];
          rd++;
          if (d.kind == K_NORM)       n = 64;
          else if (d.kind == K_ABORT) n = (d.abort_at - 1) / (ST + 1);
          else                        n = 0;
          esig = model_sig(d.tt, n);
          check_eq($sformatf("done[st%0d]", ST), bus.done, (d.kind == K_NORM) ? 1 : 0);
          check_eq($sformatf("vec_cnt[st%0d]", ST), bus.vec_cnt, n);
          check_eq($sformatf("sig[st%0d]", ST), bus.sig_o, esig);
          check_eq($sformatf("pat_end[st%0d]", ST), bus.pat_o, (d.kind == K_NORM) ? 63 : n);
          if (d.kind != K_RST) begin
            check_eq($sformatf("busy_cycles[st%0d]", ST), cyc,
                     (d.kind == K_NORM) ? 64 * (ST + 1) : d.abort_at);
            if (d.kind == K_NORM && run != ST + 1) bad = 1'b1;
            check_eq($sformatf("pat_seq[st%0d]", ST), bad, 0);
          end
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
          if (d.kind == K_NORM) begin
            gpend = 1'b1;
            gexp  = d.gold_pass;
          end else begin
            check_eq($sformatf("pf_clear[st%0d]", ST), {bus.pass, bus.fail}, 0);
          end
`endif
        end
      end
      if (fin && !drained) begin
        check_eq($sformatf("drain[st%0d]", ST), rd, exp_q.size());
        drained = 1'b1;
      end
      bprev = bus.busy;
      dprev = bus.done;
    end
  end

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_sig[%0d]", tag, k), sig_all[k], 16'hFFFF);
      check_eq($sformatf("%s_vec[%0d]", tag, k), vec_all[k], 0);
      check_eq($sformatf("%s_pat[%0d]", tag, k), pat_all[k], 0);
    end
    check_eq({tag, "_busy"}, busy_all, 0);
    check_eq({tag, "_done"}, done_all, 0);
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
    check_eq({tag, "_pass"}, pass_all, 0);
    check_eq({tag, "_fail"}, fail_all, 0);
`endif
  endtask

  // mode 3 reuses the previous truth table (repeat sweep).
  task automatic run_sweep(input int kind, input int mode, input int abort_at,
                           input int rst_at, input bit ign, input bit gpass);
    exp_t e;
    if (mode != 3) tt_cur = mk_tt(mode);
    e.kind      = kind;
    e.abort_at  = abort_at;
    e.tt        = tt_cur;
    e.gold_pass = gpass;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
    golden_v = model_sig(tt_cur, 64) ^ (gpass ? 16'h0000 : 16'h0001);
`endif
    exp_q.push_back(e);
    @(negedge clk);
    start_v = 1'b1;
    for (int c = 1; c <= 270; c++) begin
      @(negedge clk);
      start_v = ign && (c >= 2) && (c <= 60) && ($urandom_range(0, 3) == 0);
      abort_v = (c == abort_at);
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        #1 rst_n = 1'b1;
      end
    end
    start_v = 1'b0;
    abort_v = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_v = 1'b0;
    abort_v = 1'b0;
    tt_cur  = '0;
    fin     = 1'b0;
    checks  = 0;
    errors  = 0;
`ifdef CASE6_SWEEP_GOLDEN_CMP_EN
    golden_v = '0;
`endif
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(K_NORM, 0, 0, 0, 1'b0, 1'b1);
    run_sweep(K_NORM, 1, 0, 0, 1'b0, 1'b0);
    run_sweep(K_NORM, 3, 0, 0, 1'b0, 1'b1);

    // start and abort together in IDLE: nothing may start
    @(negedge clk);
    start_v = 1'b1;
    abort_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    abort_v = 1'b0;
    check_eq("start_abort_busy", busy_all, 0);
    @(negedge clk);
    check_eq("start_abort_busy2", busy_all, 0);

    run_sweep(K_ABORT, 2, 21, 0, 1'b0, 1'b0);
    run_sweep(K_NORM, 1, 0, 0, 1'b0, 1'b1);
    run_sweep(K_NORM, 2, 0, 0, 1'b1, 1'b1);
    run_sweep(K_RST, 2, 0, 30, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1)
        run_sweep(K_ABORT, 2, int'($urandom_range(1, 60)), 0, 1'b0, 1'b0);
      else
        run_sweep(K_NORM, 2, 0, 0, 1'b1, (i == 2));
    end

    fin = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
